// File: rtl/control_unit_if.sv
// control_unit_if: bundles the instruction fields, ALU flags and every datapath control
// wire that pass between the multicycle controller and the MIPS datapath.
// master: the controller side (drives controls, reads decode fields and flags).
// slave:  the datapath side (reads controls, drives decode fields and flags).
interface control_unit_if;
   // Decode inputs and ALU flags
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       alu_eq;
   logic       overflow;

   // Load and write enables
   logic       PC_write;
   logic       wr;
   logic       sel_ir;
   logic       AB_load;
   logic       aluout_load;
   logic       MDR_load;
   logic       EPC_load;
   logic       regwrite;

   // Mux selects and ALU operation
   logic       sel_alusrca;
   logic [1:0] sel_alusrcb;
   logic [2:0] alu_op;
   logic [2:0] sel_mux_iord;
   logic [1:0] sel_pc_source;
   logic [1:0] sel_regdst;
   logic [1:0] sel_memtoreg;

   // Current controller state, for debug
   logic [4:0] state;

   modport master (
      input  opcode, funct, alu_eq, overflow,
      output PC_write, wr, sel_ir, AB_load, aluout_load, MDR_load, EPC_load, regwrite,
      output sel_alusrca, sel_alusrcb, alu_op, sel_mux_iord, sel_pc_source,
      output sel_regdst, sel_memtoreg, state
   );

   modport slave (
      output opcode, funct, alu_eq, overflow,
      input  PC_write, wr, sel_ir, AB_load, aluout_load, MDR_load, EPC_load, regwrite,
      input  sel_alusrca, sel_alusrcb, alu_op, sel_mux_iord, sel_pc_source,
      input  sel_regdst, sel_memtoreg, state
   );
endinterface

// File: rtl/control_unit.sv
// control_unit: multicycle main controller for the MIPS datapath.
// Moore FSM: all controls decode from the registered state, except BRANCH PC_write
// (follows alu_eq) and the overflow exit from R_EXEC / ADDI_EXEC.
// Build option: define CTRL_EXCEPTIONS_EN to route overflow and invalid instructions
// through EXC1/EXC2 to the exception vector. Without it, overflow is ignored, invalid
// instructions retire as NOPs and EPC_load stays 0.
module control_unit #(
   parameter logic [1:0] EXC_VECTOR_SEL = 2'd3
) (
   input logic           clk,
   input logic           reset,
   control_unit_if.master bus
);

   // State encoding
   localparam logic [4:0] RESET     = 5'd0;
   localparam logic [4:0] FETCH1    = 5'd1;
   localparam logic [4:0] FETCH2    = 5'd2;
   localparam logic [4:0] DECODE    = 5'd3;
   localparam logic [4:0] R_EXEC    = 5'd4;
   localparam logic [4:0] R_WB      = 5'd5;
   localparam logic [4:0] ADDI_EXEC = 5'd6;
   localparam logic [4:0] ADDI_WB   = 5'd7;
   localparam logic [4:0] MEM_ADDR  = 5'd8;
   localparam logic [4:0] LW_WAIT   = 5'd9;
   localparam logic [4:0] LW_MDR    = 5'd10;
   localparam logic [4:0] LW_WB     = 5'd11;
   localparam logic [4:0] SW_WRITE  = 5'd12;
   localparam logic [4:0] BRANCH    = 5'd13;
   localparam logic [4:0] JUMP      = 5'd14;
   localparam logic [4:0] EXC1      = 5'd15;
   localparam logic [4:0] EXC2      = 5'd16;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;

   // Mux select codes
   localparam logic       SRCA_PC     = 1'b0;
   localparam logic       SRCA_A      = 1'b1;
   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMMSH  = 2'd3;
   localparam logic [2:0] IORD_PC     = 3'd0;
   localparam logic [2:0] IORD_ALU    = 3'd1;
   localparam logic [1:0] PCSRC_ALU   = 2'd0;
   localparam logic [1:0] PCSRC_OUT   = 2'd1;
   localparam logic [1:0] PCSRC_JUMP  = 2'd2;
   localparam logic [1:0] REGDST_RT   = 2'd0;
   localparam logic [1:0] REGDST_RD   = 2'd1;
   localparam logic [1:0] M2R_ALUOUT  = 2'd0;
   localparam logic [1:0] M2R_MDR     = 2'd1;

   logic [4:0] state_q, state_d;
   logic       funct_valid;
   logic       funct_traps;
   logic [4:0] invalid_next;

   // R-type instructions we implement; AND cannot overflow so it never traps
   assign funct_valid = (bus.funct == FN_ADD) || (bus.funct == FN_SUB) ||
                        (bus.funct == FN_AND);
   assign funct_traps = (bus.funct != FN_AND);

`ifdef CTRL_EXCEPTIONS_EN
   assign invalid_next = EXC1;
`else
   // Invalid instructions retire as NOPs and overflow is ignored
   assign invalid_next = FETCH1;
   logic unused_overflow;
   assign unused_overflow = bus.overflow;
`endif

   // State register; reset wins over every transition, including mid-instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = RESET;
      case (state_q)
         RESET:  state_d = FETCH1;
         FETCH1: state_d = FETCH2;
         FETCH2: state_d = DECODE;
         DECODE: begin
            case (bus.opcode)
               OP_RTYPE:      state_d = funct_valid ? R_EXEC : invalid_next;
               OP_ADDI:       state_d = ADDI_EXEC;
               OP_LW, OP_SW:  state_d = MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = BRANCH;
               OP_J:          state_d = JUMP;
               default:       state_d = invalid_next;
            endcase
         end
         R_EXEC: begin
`ifdef CTRL_EXCEPTIONS_EN
            state_d = (bus.overflow && funct_traps) ? EXC1 : R_WB;
`else
            state_d = R_WB;
`endif
         end
         R_WB: state_d = FETCH1;
         ADDI_EXEC: begin
`ifdef CTRL_EXCEPTIONS_EN
            state_d = bus.overflow ? EXC1 : ADDI_WB;
`else
            state_d = ADDI_WB;
`endif
         end
         ADDI_WB:  state_d = FETCH1;
         // Opcode is still held in the instruction register here
         MEM_ADDR: state_d = (bus.opcode == OP_SW) ? SW_WRITE : LW_WAIT;
         LW_WAIT:  state_d = LW_MDR;
         LW_MDR:   state_d = LW_WB;
         LW_WB:    state_d = FETCH1;
         SW_WRITE: state_d = FETCH1;
         BRANCH:   state_d = FETCH1;
         JUMP:     state_d = FETCH1;
         EXC1:     state_d = EXC2;
         EXC2:     state_d = FETCH1;
         default:  state_d = RESET;
      endcase
   end

   // Control outputs decoded from the registered state (BRANCH PC_write also reads alu_eq)
   always_comb begin
      bus.PC_write      = 1'b0;
      bus.wr            = 1'b0;
      bus.sel_ir        = 1'b0;
      bus.AB_load       = 1'b0;
      bus.aluout_load   = 1'b0;
      bus.MDR_load      = 1'b0;
      bus.EPC_load      = 1'b0;
      bus.regwrite      = 1'b0;
      bus.sel_alusrca   = SRCA_PC;
      bus.sel_alusrcb   = SRCB_B;
      bus.alu_op        = 3'b000;
      bus.sel_mux_iord  = IORD_PC;
      bus.sel_pc_source = PCSRC_ALU;
      bus.sel_regdst    = REGDST_RT;
      bus.sel_memtoreg  = M2R_ALUOUT;
      case (state_q)
         FETCH1: begin
            bus.sel_mux_iord = IORD_PC;
         end
         FETCH2: begin
            bus.sel_mux_iord  = IORD_PC;
            bus.sel_ir        = 1'b1;
            bus.sel_alusrca   = SRCA_PC;
            bus.sel_alusrcb   = SRCB_FOUR;
            bus.alu_op        = ALU_ADD;
            bus.sel_pc_source = PCSRC_ALU;
            bus.PC_write      = 1'b1;
         end
         DECODE: begin
            // Speculative branch target PC + (imm << 2) into ALUOut
            bus.AB_load     = 1'b1;
            bus.sel_alusrca = SRCA_PC;
            bus.sel_alusrcb = SRCB_IMMSH;
            bus.alu_op      = ALU_ADD;
            bus.aluout_load = 1'b1;
         end
         R_EXEC: begin
            bus.sel_alusrca = SRCA_A;
            bus.sel_alusrcb = SRCB_B;
            bus.aluout_load = 1'b1;
            case (bus.funct)
               FN_SUB:  bus.alu_op = ALU_SUB;
               FN_AND:  bus.alu_op = ALU_AND;
               default: bus.alu_op = ALU_ADD;
            endcase
         end
         R_WB: begin
            bus.sel_regdst   = REGDST_RD;
            bus.sel_memtoreg = M2R_ALUOUT;
            bus.regwrite     = 1'b1;
         end
         ADDI_EXEC: begin
            bus.sel_alusrca = SRCA_A;
            bus.sel_alusrcb = SRCB_IMM;
            bus.alu_op      = ALU_ADD;
            bus.aluout_load = 1'b1;
         end
         ADDI_WB: begin
            bus.sel_regdst   = REGDST_RT;
            bus.sel_memtoreg = M2R_ALUOUT;
            bus.regwrite     = 1'b1;
         end
         // Address stays on the memory bus from MEM_ADDR through LW_MDR
         MEM_ADDR, LW_WAIT: begin
            bus.sel_alusrca  = SRCA_A;
            bus.sel_alusrcb  = SRCB_IMM;
            bus.alu_op       = ALU_ADD;
            bus.sel_mux_iord = IORD_ALU;
         end
         LW_MDR: begin
            bus.sel_alusrca  = SRCA_A;
            bus.sel_alusrcb  = SRCB_IMM;
            bus.alu_op       = ALU_ADD;
            bus.sel_mux_iord = IORD_ALU;
            bus.MDR_load     = 1'b1;
         end
         LW_WB: begin
            bus.sel_regdst   = REGDST_RT;
            bus.sel_memtoreg = M2R_MDR;
            bus.regwrite     = 1'b1;
         end
         SW_WRITE: begin
            bus.sel_alusrca  = SRCA_A;
            bus.sel_alusrcb  = SRCB_IMM;
            bus.alu_op       = ALU_ADD;
            bus.sel_mux_iord = IORD_ALU;
            bus.wr           = 1'b1;
         end
         BRANCH: begin
            bus.sel_alusrca   = SRCA_A;
            bus.sel_alusrcb   = SRCB_B;
            bus.alu_op        = ALU_SUB;
            bus.sel_pc_source = PCSRC_OUT;
            bus.PC_write      = (bus.opcode == OP_BNE) ? ~bus.alu_eq : bus.alu_eq;
         end
         JUMP: begin
            bus.sel_pc_source = PCSRC_JUMP;
            bus.PC_write      = 1'b1;
         end
         EXC1: begin
            // PC already points past the faulting instruction; PC - 4 goes to EPC
            bus.sel_alusrca = SRCA_PC;
            bus.sel_alusrcb = SRCB_FOUR;
            bus.alu_op      = ALU_SUB;
`ifdef CTRL_EXCEPTIONS_EN
            bus.EPC_load    = 1'b1;
`endif
         end
         EXC2: begin
            bus.sel_pc_source = EXC_VECTOR_SEL;
            bus.PC_write      = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the multicycle controller state sequences and
// control outputs. Expectations follow CTRL_EXCEPTIONS_EN when the bench is built with it.
module tb_control_unit;

   logic clk;
   logic reset;
   int   total;
   int   passed;
   int   failed;
   int   pc_cnt;
   int   rw_cnt;

   control_unit_if bus ();

   control_unit #(
      .EXC_VECTOR_SEL (2'd3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All control outputs packed, for "everything is 0" checks
   logic [22:0] outs;
   assign outs = {bus.PC_write, bus.wr, bus.sel_ir, bus.AB_load, bus.aluout_load,
                  bus.MDR_load, bus.EPC_load, bus.regwrite, bus.sel_alusrca,
                  bus.sel_alusrcb, bus.alu_op, bus.sel_mux_iord, bus.sel_pc_source,
                  bus.sel_regdst, bus.sel_memtoreg};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.PC_write === 1'b1) pc_cnt++;
      if (bus.regwrite === 1'b1) rw_cnt++;
   endtask

   task automatic step(input string tag, input logic [4:0] exp_state);
      tick();
      chk(tag, 32'(bus.state), 32'(exp_state));
   endtask

   initial begin
      total = 0; passed = 0; failed = 0; pc_cnt = 0; rw_cnt = 0;
      reset = 1'b1;
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.alu_eq = 1'b0; bus.overflow = 1'b0;

      // Reset held for two cycles
      tick();
      chk("rst1_state", 32'(bus.state), 32'd0);
      chk("rst1_outs", 32'(outs), 32'd0);
      tick();
      chk("rst2_state", 32'(bus.state), 32'd0);
      chk("rst2_outs", 32'(outs), 32'd0);
      reset = 1'b0;
      step("rst_release", 5'd1);

      // add, no overflow
      bus.opcode = 6'h00; bus.funct = 6'h20;
      pc_cnt = 0; rw_cnt = 0;
      chk("add_f1_iord", 32'(bus.sel_mux_iord), 32'd0);
      step("add_s2", 5'd2);
      chk("add_f2_pcw", 32'(bus.PC_write), 32'd1);
      chk("add_f2_ir", 32'(bus.sel_ir), 32'd1);
      chk("add_f2_srcb", 32'(bus.sel_alusrcb), 32'd1);
      step("add_s3", 5'd3);
      chk("add_dec_ab", 32'(bus.AB_load), 32'd1);
      chk("add_dec_srcb", 32'(bus.sel_alusrcb), 32'd3);
      step("add_s4", 5'd4);
      chk("add_ex_aluop", 32'(bus.alu_op), 32'd1);
      chk("add_ex_srca", 32'(bus.sel_alusrca), 32'd1);
      step("add_s5", 5'd5);
      chk("add_wb_rw", 32'(bus.regwrite), 32'd1);
      chk("add_wb_dst", 32'(bus.sel_regdst), 32'd1);
      step("add_s1", 5'd1);
      chk("add_pcw_cnt", 32'(pc_cnt), 32'd1);
      chk("add_rw_cnt", 32'(rw_cnt), 32'd1);

      // sub: ALU op follows funct
      bus.funct = 6'h22;
      step("sub_s2", 5'd2);
      step("sub_s3", 5'd3);
      step("sub_s4", 5'd4);
      chk("sub_aluop", 32'(bus.alu_op), 32'd2);
      step("sub_s5", 5'd5);
      step("sub_s1", 5'd1);

      // lw
      bus.opcode = 6'h23;
      step("lw_s2", 5'd2);
      step("lw_s3", 5'd3);
      step("lw_s8", 5'd8);
      chk("lw8_iord", 32'(bus.sel_mux_iord), 32'd1);
      chk("lw8_mdr", 32'(bus.MDR_load), 32'd0);
      step("lw_s9", 5'd9);
      chk("lw9_iord", 32'(bus.sel_mux_iord), 32'd1);
      step("lw_s10", 5'd10);
      chk("lw10_iord", 32'(bus.sel_mux_iord), 32'd1);
      chk("lw10_mdr", 32'(bus.MDR_load), 32'd1);
      step("lw_s11", 5'd11);
      chk("lw11_rw", 32'(bus.regwrite), 32'd1);
      chk("lw11_m2r", 32'(bus.sel_memtoreg), 32'd1);
      chk("lw11_mdr", 32'(bus.MDR_load), 32'd0);
      step("lw_s1", 5'd1);

      // sw
      bus.opcode = 6'h2B;
      step("sw_s2", 5'd2);
      step("sw_s3", 5'd3);
      step("sw_s8", 5'd8);
      chk("sw8_wr", 32'(bus.wr), 32'd0);
      step("sw_s12", 5'd12);
      chk("sw12_wr", 32'(bus.wr), 32'd1);
      chk("sw12_iord", 32'(bus.sel_mux_iord), 32'd1);
      step("sw_s1", 5'd1);

      // beq taken, then not taken
      bus.opcode = 6'h04; bus.alu_eq = 1'b1;
      step("beq1_s2", 5'd2);
      step("beq1_s3", 5'd3);
      step("beq1_s13", 5'd13);
      chk("beq1_pcw", 32'(bus.PC_write), 32'd1);
      chk("beq1_pcsrc", 32'(bus.sel_pc_source), 32'd1);
      chk("beq1_aluop", 32'(bus.alu_op), 32'd2);
      step("beq1_s1", 5'd1);
      bus.alu_eq = 1'b0;
      step("beq0_s2", 5'd2);
      step("beq0_s3", 5'd3);
      step("beq0_s13", 5'd13);
      chk("beq0_pcw", 32'(bus.PC_write), 32'd0);
      chk("beq0_pcsrc", 32'(bus.sel_pc_source), 32'd1);
      // Mealy output: PC_write tracks alu_eq within the state
      bus.alu_eq = 1'b1;
      #1;
      chk("beq_mealy_pcw", 32'(bus.PC_write), 32'd1);
      bus.alu_eq = 1'b0;
      step("beq0_s1", 5'd1);

      // bne, not equal -> taken
      bus.opcode = 6'h05;
      step("bne_s2", 5'd2);
      step("bne_s3", 5'd3);
      step("bne_s13", 5'd13);
      chk("bne_pcw", 32'(bus.PC_write), 32'd1);
      step("bne_s1", 5'd1);

      // j
      bus.opcode = 6'h02;
      step("j_s2", 5'd2);
      step("j_s3", 5'd3);
      step("j_s14", 5'd14);
      chk("j_pcw", 32'(bus.PC_write), 32'd1);
      chk("j_pcsrc", 32'(bus.sel_pc_source), 32'd2);
      step("j_s1", 5'd1);

      // addi with overflow
      bus.opcode = 6'h08;
      rw_cnt = 0;
      step("addi_s2", 5'd2);
      step("addi_s3", 5'd3);
      step("addi_s6", 5'd6);
      chk("addi_srcb", 32'(bus.sel_alusrcb), 32'd2);
      bus.overflow = 1'b1;
`ifdef CTRL_EXCEPTIONS_EN
      step("ovf_s15", 5'd15);
      bus.overflow = 1'b0;
      chk("ovf_epc", 32'(bus.EPC_load), 32'd1);
      chk("ovf_aluop", 32'(bus.alu_op), 32'd2);
      chk("ovf_srcb", 32'(bus.sel_alusrcb), 32'd1);
      step("ovf_s16", 5'd16);
      chk("ovf_pcsrc", 32'(bus.sel_pc_source), 32'd3);
      chk("ovf_pcw", 32'(bus.PC_write), 32'd1);
      step("ovf_s1", 5'd1);
      chk("ovf_no_rw", 32'(rw_cnt), 32'd0);
`else
      step("ovf_s7", 5'd7);
      bus.overflow = 1'b0;
      chk("ovf_rw", 32'(bus.regwrite), 32'd1);
      chk("ovf_epc", 32'(bus.EPC_load), 32'd0);
      step("ovf_s1", 5'd1);
`endif

      // invalid opcode
      bus.opcode = 6'h3F;
      step("inv_s2", 5'd2);
      step("inv_s3", 5'd3);
`ifdef CTRL_EXCEPTIONS_EN
      step("inv_s15", 5'd15);
      step("inv_s16", 5'd16);
      step("inv_s1", 5'd1);
`else
      step("inv_s1", 5'd1);
`endif

      // reset in the middle of a load
      bus.opcode = 6'h23;
      step("lwr_s2", 5'd2);
      step("lwr_s3", 5'd3);
      step("lwr_s8", 5'd8);
      step("lwr_s9", 5'd9);
      reset = 1'b1;
      step("lwr_s0", 5'd0);
      chk("lwr_outs", 32'(outs), 32'd0);
      reset = 1'b0;
      step("lwr_s1", 5'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle main controller for the MIPS CPU datapath. It is a Moore-style FSM, with two Mealy exceptions. Each cycle it decodes the instruction register fields and drives the load enables, mux selects, ALU operation and memory write strobe for the PC, A/B, ALUOut, MDR, EPC, memory, register bank and ALU. It sits beside the datapath inside `CPU` and is the only source of the datapath control wires.

## Interface
Parameters:
- EXC_VECTOR_SEL, 2'd3: `sel_pc_source` code that selects the exception-vector constant in the PC source mux.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction bits [31:26], from `Instr_Reg`
- funct  in  6  instruction bits [5:0]
- alu_eq  in  1  ALU equal flag
- overflow  in  1  ALU overflow flag
- PC_write, wr, sel_ir, AB_load, aluout_load, MDR_load, EPC_load, regwrite  out  1 each  load/write enables
- sel_alusrca  out  1  0=PC, 1=A
- sel_alusrcb  out  2  0=B, 1=const 4, 2=signext(imm), 3=signext(imm)<<2
- alu_op  out  3  ula32 code: 001 add, 010 sub, 011 and
- sel_mux_iord  out  3  0=PC, 1=ALU result
- sel_pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=vector
- sel_regdst  out  2  0=rt, 1=rd
- sel_memtoreg  out  2  0=ALUOut, 1=MDR
- state  out  5  current state encoding, for debug and bench

## Operation
- State encoding:
  - RESET=0, FETCH1=1, FETCH2=2, DECODE=3
  - R_EXEC=4, R_WB=5, ADDI_EXEC=6, ADDI_WB=7
  - MEM_ADDR=8, LW_WAIT=9, LW_MDR=10, LW_WB=11, SW_WRITE=12
  - BRANCH=13, JUMP=14, EXC1=15, EXC2=16
- Default output value in every state is 0; only the values listed below are driven.
- RESET: all outputs 0. Next state FETCH1.
- FETCH1: iord=0. Next FETCH2.
- FETCH2: iord=0, sel_ir=1, srca=0, srcb=1, alu_op=add, pc_source=0, PC_write=1. Next DECODE.
- DECODE: AB_load=1, srca=0, srcb=3, add, aluout_load=1. Dispatch on opcode:
  - 0x00 with funct 0x20/0x22/0x24 -> R_EXEC
  - 0x08 -> ADDI_EXEC
  - 0x23/0x2B -> MEM_ADDR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - anything else -> invalid
- R_EXEC: srca=1, srcb=0, alu_op from funct (add/sub/and), aluout_load=1. Next R_WB, or EXC1 on overflow for add/sub.
- R_WB: regdst=1, memtoreg=0, regwrite=1. Next FETCH1.
- ADDI_EXEC: srca=1, srcb=2, add, aluout_load=1. Next ADDI_WB, or EXC1 on overflow.
- ADDI_WB: regdst=0, memtoreg=0, regwrite=1. Next FETCH1.
- MEM_ADDR: srca=1, srcb=2, add, iord=1. Next LW_WAIT (lw) or SW_WRITE (sw).
- LW_WAIT: same ALU and iord values as MEM_ADDR. Next LW_MDR.
- LW_MDR: same values, plus MDR_load=1. Next LW_WB.
- LW_WB: regdst=0, memtoreg=1, regwrite=1. Next FETCH1.
- SW_WRITE: srca=1, srcb=2, add, iord=1, wr=1. Next FETCH1.
- BRANCH: srca=1, srcb=0, sub, pc_source=1. PC_write = alu_eq for beq and ~alu_eq for bne (Mealy). Next FETCH1.
- JUMP: pc_source=2, PC_write=1. Next FETCH1.
- EXC1: srca=0, srcb=1, sub, EPC_load=1. EPC receives PC-4, the address of the faulting instruction. Next EXC2.
- EXC2: pc_source=EXC_VECTOR_SEL, PC_write=1. Next FETCH1.
- Overflow aborts the instruction: regwrite is never asserted for it.

## Timing
- Outputs are combinational from the registered state. Only BRANCH PC_write and the R_EXEC/ADDI_EXEC next-state choice depend on inputs.
- Instruction latency in cycles:
  - R-type, addi: 5
  - lw: 7
  - sw: 5
  - beq/bne, j: 4
  - exception path: 6 from FETCH1 to vector fetch
- reset is sampled at the clk edge and overrides all transitions, including mid-instruction. The next state is RESET.
- A store interrupted by reset has had wr asserted for at most the cycle before reset.
- wr is never asserted in the same cycle as sel_ir or MDR_load.

## Configuration
- Macro `CTRL_EXCEPTIONS_EN`.
- Defined: overflow and invalid opcode/funct go to EXC1/EXC2 as described above.
- Undefined: overflow is ignored (R_EXEC->R_WB, ADDI_EXEC->ADDI_WB). An invalid instruction goes from DECODE to FETCH1 as a NOP. EPC_load is tied 0 and EXC1/EXC2 are unreachable.

## Test plan
- reset held 2 cycles, then released: state=0 and all outputs 0 while reset is held, state=1 on the first edge after release.
- add (opcode 0x00, funct 0x20), no overflow: state sequence 1,2,3,4,5,1. regwrite=1 with regdst=1 only in state 5. PC_write pulses once, in state 2.
- lw (0x23): states 1,2,3,8,9,10,11,1. iord=1 in 8–10, MDR_load only in 10, regwrite with memtoreg=1 in 11.
- beq (0x04) with alu_eq=1, then with alu_eq=0: PC_write=1 / 0 in state 13, pc_source=1 in both cases.
- addi (0x08) with overflow=1 in state 6, macro defined: sequence 6,15,16,1, EPC_load=1 in 15, pc_source=3 with PC_write in 16, regwrite never asserted. Same stimulus without the macro: sequence 6,7,1.
- opcode 0x3F with the macro defined: 3->15. reset asserted in state 9: next state 0, all outputs 0.
